// File: rtl/pipelined_ctrl_unit_if.sv
// Control-unit bus: the ID-stage instruction stream going in, and the
// decode, hazard and pipelined control signals coming back out.
interface pipelined_ctrl_unit_if #(
    parameter int ALUC_W  = 4,
    parameter int RADDR_W = 5
);
    // Instruction stream presented to the ID stage
    logic [31:0]        instr_d;
    logic               valid_d;
    logic               flush_e;

    // Combinational ID-stage results
    logic               branch_d;
    logic               branch_ne_d;
    logic               jump_d;
    logic               stall_d;
    logic               illegal_d;

    // ID/EX control bundle
    logic               regwrite_e;
    logic               memtoreg_e;
    logic               memwrite_e;
    logic               alusrc_e;
    logic               zext_e;
    logic               link_e;
    logic               mul_start_e;
    logic [ALUC_W-1:0]  alu_ctrl_e;
    logic [RADDR_W-1:0] write_reg_e;

    // EX/MEM control bundle
    logic               regwrite_m;
    logic               memtoreg_m;
    logic [RADDR_W-1:0] write_reg_m;

    // Side that feeds instructions in and consumes the control signals
    modport master (
        output instr_d, valid_d, flush_e,
        input  branch_d, branch_ne_d, jump_d, stall_d, illegal_d,
        input  regwrite_e, memtoreg_e, memwrite_e, alusrc_e, zext_e, link_e,
        input  mul_start_e, alu_ctrl_e, write_reg_e,
        input  regwrite_m, memtoreg_m, write_reg_m
    );

    // Side implemented by the control unit itself
    modport slave (
        input  instr_d, valid_d, flush_e,
        output branch_d, branch_ne_d, jump_d, stall_d, illegal_d,
        output regwrite_e, memtoreg_e, memwrite_e, alusrc_e, zext_e, link_e,
        output mul_start_e, alu_ctrl_e, write_reg_e,
        output regwrite_m, memtoreg_m, write_reg_m
    );
endinterface

// File: rtl/pipelined_ctrl_unit.sv
// Decode and control for the 5-stage MIPS pipeline. Decodes the ID
// instruction, carries its control bundle through ID/EX and EX/MEM, and
// stalls ID (with an EX bubble) on load-use, branch-operand and
// multiplier-busy hazards. A small FSM tracks multi-cycle mult occupancy.
module pipelined_ctrl_unit #(
    parameter int ALUC_W  = 4,
    parameter int RADDR_W = 5,
    parameter int MUL_LAT = 4
) (
    input logic                  clk,
    input logic                  reset,
    pipelined_ctrl_unit_if.slave bus
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    // ALU operation codes (zero-filled up to ALUC_W on the output)
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    // Multiplier occupancy counter sizing; a latency of 1 never goes busy
    localparam int          CNT_W     = $clog2(MUL_LAT + 1);
    localparam logic        MUL_MULTI = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE,
        BUSY
    } mulState_t;

    // Control bundle carried from ID into EX
    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
        logic               alusrc;
        logic               zext;
        logic               link;
        logic               mulStart;
        logic [3:0]         aluOp;
        logic [RADDR_W-1:0] writeReg;
    } ctrl_t;

    // Instruction fields
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [RADDR_W-1:0] rsD;
    logic [RADDR_W-1:0] rtD;
    logic [RADDR_W-1:0] rdD;
    logic               unusedShamt;

    // Decoder results
    logic               decRegwrite;
    logic               decMemtoreg;
    logic               decMemwrite;
    logic               decAlusrc;
    logic               decZext;
    logic               decLink;
    logic               decMult;
    logic               decMfhilo;
    logic               decBranch;
    logic               decBranchNe;
    logic               decJump;
    logic               decIllegal;
    logic               decRtSrc;
    logic               decIsR;
    logic [3:0]         decAluOp;
    logic [RADDR_W-1:0] decWriteReg;

    // Hazard terms
    logic               loadUseHaz;
    logic               branchHaz;
    logic               mulBusyHaz;
    logic               stall;
    logic               mulBusy;

    // Pipeline and FSM state
    ctrl_t              idEx_d;
    ctrl_t              idEx_q;
    logic               memRegwrite_q;
    logic               memMemtoreg_q;
    logic [RADDR_W-1:0] memWriteReg_q;
    mulState_t          state_d;
    mulState_t          state_q;
    logic [CNT_W-1:0]   mulCnt_d;
    logic [CNT_W-1:0]   mulCnt_q;

    assign opcode = bus.instr_d[31:26];
    assign funct  = bus.instr_d[5:0];
    assign rsD    = RADDR_W'(bus.instr_d[25:21]);
    assign rtD    = RADDR_W'(bus.instr_d[20:16]);
    assign rdD    = RADDR_W'(bus.instr_d[15:11]);
    // Shift amount belongs to the datapath, not to control
    assign unusedShamt = ^bus.instr_d[10:6];

    // Main decoder: opcode, then funct for R-type, into control flags and ALU op
    always_comb begin
        decRegwrite = 1'b0;
        decMemtoreg = 1'b0;
        decMemwrite = 1'b0;
        decAlusrc   = 1'b0;
        decZext     = 1'b0;
        decLink     = 1'b0;
        decMult     = 1'b0;
        decMfhilo   = 1'b0;
        decBranch   = 1'b0;
        decBranchNe = 1'b0;
        decJump     = 1'b0;
        decIllegal  = 1'b0;
        decRtSrc    = 1'b0;
        decIsR      = 1'b0;
        decAluOp    = ALU_AND;
        case (opcode)
            OP_RTYPE: begin
                decIsR   = 1'b1;
                decRtSrc = 1'b1;
                case (funct)
                    FN_ADD:  begin decRegwrite = 1'b1; decAluOp = ALU_ADD; end
                    FN_SUB:  begin decRegwrite = 1'b1; decAluOp = ALU_SUB; end
                    FN_AND:  begin decRegwrite = 1'b1; decAluOp = ALU_AND; end
                    FN_OR:   begin decRegwrite = 1'b1; decAluOp = ALU_OR;  end
                    FN_NOR:  begin decRegwrite = 1'b1; decAluOp = ALU_NOR; end
                    FN_SLT:  begin decRegwrite = 1'b1; decAluOp = ALU_SLT; end
                    FN_SLL:  begin decRegwrite = 1'b1; decAluOp = ALU_SLL; end
                    FN_SRL:  begin decRegwrite = 1'b1; decAluOp = ALU_SRL; end
                    FN_MULT: decMult = 1'b1;
                    FN_MFHI, FN_MFLO: begin
                        decRegwrite = 1'b1;
                        decMfhilo   = 1'b1;
                    end
                    default: decIllegal = 1'b1;
                endcase
            end
            OP_LW: begin
                decRegwrite = 1'b1;
                decMemtoreg = 1'b1;
                decAlusrc   = 1'b1;
                decAluOp    = ALU_ADD;
            end
            OP_SW: begin
                decMemwrite = 1'b1;
                decAlusrc   = 1'b1;
                decRtSrc    = 1'b1;
                decAluOp    = ALU_ADD;
            end
            OP_BEQ: begin
                decBranch = 1'b1;
                decRtSrc  = 1'b1;
                decAluOp  = ALU_SUB;
            end
            OP_BNE: begin
                decBranchNe = 1'b1;
                decRtSrc    = 1'b1;
                decAluOp    = ALU_SUB;
            end
            OP_ADDI: begin
                decRegwrite = 1'b1;
                decAlusrc   = 1'b1;
                decAluOp    = ALU_ADD;
            end
            OP_ANDI: begin
                decRegwrite = 1'b1;
                decAlusrc   = 1'b1;
                decZext     = 1'b1;
                decAluOp    = ALU_AND;
            end
            OP_ORI: begin
                decRegwrite = 1'b1;
                decAlusrc   = 1'b1;
                decZext     = 1'b1;
                decAluOp    = ALU_OR;
            end
            OP_SLTI: begin
                decRegwrite = 1'b1;
                decAlusrc   = 1'b1;
                decAluOp    = ALU_SLT;
            end
            OP_J: begin
                decJump = 1'b1;
            end
            OP_JAL: begin
                decJump     = 1'b1;
                decLink     = 1'b1;
                decRegwrite = 1'b1;
                decAluOp    = ALU_ADD;
            end
            default: decIllegal = 1'b1;
        endcase
    end

    // Destination register: jal links into $31, R-type writes rd, the rest rt
    always_comb begin
        decWriteReg = rtD;
        if (opcode == OP_JAL) begin
            decWriteReg = RADDR_W'(31);
        end else if (decIsR) begin
            decWriteReg = rdD;
        end
    end

    // Hazard detection against the instructions now in EX and MEM
    always_comb begin
        loadUseHaz = idEx_q.memtoreg && (idEx_q.writeReg != '0) &&
                     ((idEx_q.writeReg == rsD) || (decRtSrc && (idEx_q.writeReg == rtD)));
        branchHaz  = (decBranch || decBranchNe) &&
                     ((idEx_q.regwrite && (idEx_q.writeReg != '0) &&
                       ((idEx_q.writeReg == rsD) || (idEx_q.writeReg == rtD))) ||
                      (memMemtoreg_q && (memWriteReg_q != '0) &&
                       ((memWriteReg_q == rsD) || (memWriteReg_q == rtD))));
        mulBusyHaz = mulBusy && (decMult || decMfhilo);
        stall      = bus.valid_d && (loadUseHaz || branchHaz || mulBusyHaz);
    end

    // Next ID/EX contents: the decoded bundle, or a bubble when it must not issue
    always_comb begin
        idEx_d = '0;
        if (!(bus.flush_e || stall || !bus.valid_d || decIllegal)) begin
            idEx_d.regwrite = decRegwrite;
            idEx_d.memtoreg = decMemtoreg;
            idEx_d.memwrite = decMemwrite;
            idEx_d.alusrc   = decAlusrc;
            idEx_d.zext     = decZext;
            idEx_d.link     = decLink;
            idEx_d.mulStart = decMult;
            idEx_d.aluOp    = decAluOp;
            idEx_d.writeReg = decWriteReg;
        end
    end

    // ID/EX and EX/MEM pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idEx_q        <= '0;
            memRegwrite_q <= 1'b0;
            memMemtoreg_q <= 1'b0;
            memWriteReg_q <= '0;
        end else begin
            idEx_q        <= idEx_d;
            memRegwrite_q <= idEx_q.regwrite;
            memMemtoreg_q <= idEx_q.memtoreg;
            memWriteReg_q <= idEx_q.writeReg;
        end
    end

    // Multiplier FSM state register; reset abandons any in-flight mult
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mulCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mulCnt_q <= mulCnt_d;
        end
    end

    // Multiplier FSM next state: go busy when a mult enters EX, count down the rest
    always_comb begin
        state_d  = state_q;
        mulCnt_d = mulCnt_q;
        case (state_q)
            IDLE: begin
                if (idEx_d.mulStart && MUL_MULTI) begin
                    state_d  = BUSY;
                    mulCnt_d = CNT_START;
                end
            end
            BUSY: begin
                if (mulCnt_q == CNT_ONE) begin
                    state_d  = IDLE;
                    mulCnt_d = '0;
                end else begin
                    mulCnt_d = mulCnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d  = IDLE;
                mulCnt_d = '0;
            end
        endcase
    end

    // Multiplier FSM outputs
    always_comb begin
        mulBusy = (state_q == BUSY);
    end

    assign bus.branch_d    = decBranch;
    assign bus.branch_ne_d = decBranchNe;
    assign bus.jump_d      = decJump;
    assign bus.illegal_d   = decIllegal;
    assign bus.stall_d     = stall;

    assign bus.regwrite_e  = idEx_q.regwrite;
    assign bus.memtoreg_e  = idEx_q.memtoreg;
    assign bus.memwrite_e  = idEx_q.memwrite;
    assign bus.alusrc_e    = idEx_q.alusrc;
    assign bus.zext_e      = idEx_q.zext;
    assign bus.link_e      = idEx_q.link;
    assign bus.mul_start_e = idEx_q.mulStart;
    assign bus.alu_ctrl_e  = ALUC_W'(idEx_q.aluOp);
    assign bus.write_reg_e = idEx_q.writeReg;

    assign bus.regwrite_m  = memRegwrite_q;
    assign bus.memtoreg_m  = memMemtoreg_q;
    assign bus.write_reg_m = memWriteReg_q;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Self-checking bench for pipelined_ctrl_unit. Each cycle an instruction is
// driven into ID with the stall it should cause; the EX bundle it should
// produce is queued and compared one cycle later, and the MEM copy the
// cycle after that.
module tb_pipelined_ctrl_unit;

    localparam int ALUC_W  = 4;
    localparam int RADDR_W = 5;
    localparam int MUL_LAT = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Expected EX bundle {rw,mtr,mw,as,zx,lk,ms,alu[3:0],wr[4:0]}
    logic [15:0] exQ[$];
    // Expected MEM bundle {rw,mtr,wr[4:0]}
    logic [6:0]  memExp;

    logic [31:0] misc[$];

    pipelined_ctrl_unit_if #(.ALUC_W(ALUC_W), .RADDR_W(RADDR_W)) bus ();

    pipelined_ctrl_unit #(
        .ALUC_W (ALUC_W),
        .RADDR_W(RADDR_W),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_R, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference decode table: {branch,bne,jump,illegal, EX bundle}
    function automatic logic [19:0] refDecode(input logic [31:0] ins);
        logic [4:0] rt;
        logic [4:0] rd;
        rt = ins[20:16];
        rd = ins[15:11];
        case (ins[31:26])
            OP_R: begin
                case (ins[5:0])
                    6'b100000: return {4'b0000, 7'b1000000, 4'b0010, rd};
                    6'b100010: return {4'b0000, 7'b1000000, 4'b0110, rd};
                    6'b100100: return {4'b0000, 7'b1000000, 4'b0000, rd};
                    6'b100101: return {4'b0000, 7'b1000000, 4'b0001, rd};
                    6'b100111: return {4'b0000, 7'b1000000, 4'b0100, rd};
                    6'b101010: return {4'b0000, 7'b1000000, 4'b0111, rd};
                    6'b000000: return {4'b0000, 7'b1000000, 4'b0011, rd};
                    6'b000010: return {4'b0000, 7'b1000000, 4'b0101, rd};
                    6'b011000: return {4'b0000, 7'b0000001, 4'b0000, rd};
                    6'b010000: return {4'b0000, 7'b1000000, 4'b0000, rd};
                    6'b010010: return {4'b0000, 7'b1000000, 4'b0000, rd};
                    default:   return {4'b0001, 16'h0000};
                endcase
            end
            OP_LW:   return {4'b0000, 7'b1101000, 4'b0010, rt};
            OP_SW:   return {4'b0000, 7'b0011000, 4'b0010, rt};
            OP_BEQ:  return {4'b1000, 7'b0000000, 4'b0110, rt};
            OP_BNE:  return {4'b0100, 7'b0000000, 4'b0110, rt};
            OP_ADDI: return {4'b0000, 7'b1001000, 4'b0010, rt};
            OP_ANDI: return {4'b0000, 7'b1001100, 4'b0000, rt};
            OP_ORI:  return {4'b0000, 7'b1001100, 4'b0001, rt};
            OP_SLTI: return {4'b0000, 7'b1001000, 4'b0111, rt};
            OP_J:    return {4'b0010, 7'b0000000, 4'b0000, rt};
            OP_JAL:  return {4'b0010, 7'b1000010, 4'b0010, 5'd31};
            default: return {4'b0001, 16'h0000};
        endcase
    endfunction

    function automatic logic [15:0] exObs();
        return {bus.regwrite_e, bus.memtoreg_e, bus.memwrite_e, bus.alusrc_e,
                bus.zext_e, bus.link_e, bus.mul_start_e, bus.alu_ctrl_e[3:0],
                bus.write_reg_e};
    endfunction

    function automatic logic [6:0] memObs();
        return {bus.regwrite_m, bus.memtoreg_m, bus.write_reg_m};
    endfunction

    // Count one comparison and report it if it differs
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one ID cycle, check comb outputs and the pipeline, queue next EX
    task automatic applyStimulus(input string tag, input logic [31:0] instr,
                                 input logic valid, input logic flush,
                                 input logic expStall);
        logic [19:0] refBits;
        logic [15:0] expEx;
        refBits        = refDecode(instr);
        bus.instr_d    = instr;
        bus.valid_d    = valid;
        bus.flush_e    = flush;
        @(negedge clk);
        checkOutput({tag, "/stall"}, 32'(bus.stall_d), 32'(expStall));
        checkOutput({tag, "/decode"},
                    32'({bus.branch_d, bus.branch_ne_d, bus.jump_d, bus.illegal_d}),
                    32'(refBits[19:16]));
        expEx = exQ.pop_front();
        checkOutput({tag, "/ex"}, 32'(exObs()), 32'(expEx));
        checkOutput({tag, "/mem"}, 32'(memObs()), 32'(memExp));
        memExp = {expEx[15], expEx[14], expEx[4:0]};
        if (expStall || !valid || flush || refBits[16]) begin
            exQ.push_back(16'h0000);
        end else begin
            exQ.push_back(refBits[15:0]);
        end
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges and check every registered output cleared
    task automatic doReset(input string tag);
        reset       = 1'b1;
        bus.valid_d = 1'b0;
        bus.flush_e = 1'b0;
        bus.instr_d = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({tag, "/ex"}, 32'(exObs()), 32'h0);
        checkOutput({tag, "/mem"}, 32'(memObs()), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exQ.delete();
        exQ.push_back(16'h0000);
        memExp = 7'h00;
    endtask

    initial begin
        doReset("reset");

        // Load-use: one stall, then add issues
        applyStimulus("t1_lw",    iType(OP_LW, 5'd1, 5'd2, 16'h0), 1'b1, 1'b0, 1'b0);
        applyStimulus("t1_add_s", rType(5'd2, 5'd4, 5'd3, 6'b100000), 1'b1, 1'b0, 1'b1);
        applyStimulus("t1_add",   rType(5'd2, 5'd4, 5'd3, 6'b100000), 1'b1, 1'b0, 1'b0);
        applyStimulus("t1_nop",   32'h0, 1'b0, 1'b0, 1'b0);

        // Branch operand hazards: ALU producer one stall, load producer two
        applyStimulus("t2_add",    rType(5'd1, 5'd2, 5'd5, 6'b100000), 1'b1, 1'b0, 1'b0);
        applyStimulus("t2_beq_s",  iType(OP_BEQ, 5'd5, 5'd6, 16'h4), 1'b1, 1'b0, 1'b1);
        applyStimulus("t2_beq",    iType(OP_BEQ, 5'd5, 5'd6, 16'h4), 1'b1, 1'b0, 1'b0);
        applyStimulus("t2_lw",     iType(OP_LW, 5'd1, 5'd5, 16'h0), 1'b1, 1'b0, 1'b0);
        applyStimulus("t2_bne_s1", iType(OP_BNE, 5'd5, 5'd6, 16'h4), 1'b1, 1'b0, 1'b1);
        applyStimulus("t2_bne_s2", iType(OP_BNE, 5'd5, 5'd6, 16'h4), 1'b1, 1'b0, 1'b1);
        applyStimulus("t2_bne",    iType(OP_BNE, 5'd5, 5'd6, 16'h4), 1'b1, 1'b0, 1'b0);
        applyStimulus("t2_nop",    32'h0, 1'b0, 1'b0, 1'b0);

        // Multiplier occupancy: mflo waits three cycles behind mult
        applyStimulus("t3_mult", rType(5'd1, 5'd2, 5'd0, 6'b011000), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            applyStimulus($sformatf("t3_mflo_s%0d", i), rType(5'd0, 5'd0, 5'd7, 6'b010010),
                          1'b1, 1'b0, 1'b1);
        end
        applyStimulus("t3_mflo", rType(5'd0, 5'd0, 5'd7, 6'b010010), 1'b1, 1'b0, 1'b0);
        applyStimulus("t3_nop",  32'h0, 1'b0, 1'b0, 1'b0);

        // Jumps, immediates and the remaining R-type operations
        applyStimulus("t4_jal", {OP_JAL, 26'h0000040}, 1'b1, 1'b0, 1'b0);
        applyStimulus("t4_ori", iType(OP_ORI, 5'd1, 5'd8, 16'h00ff), 1'b1, 1'b0, 1'b0);
        misc.push_back(iType(OP_ANDI, 5'd1, 5'd11, 16'h00f0));
        misc.push_back(iType(OP_SLTI, 5'd2, 5'd12, 16'hfff0));
        misc.push_back(iType(OP_ADDI, 5'd3, 5'd13, 16'h0001));
        misc.push_back(iType(OP_SW, 5'd4, 5'd14, 16'h0008));
        misc.push_back({OP_J, 26'h0000100});
        misc.push_back(rType(5'd1, 5'd2, 5'd15, 6'b100010));
        misc.push_back(rType(5'd1, 5'd2, 5'd16, 6'b100100));
        misc.push_back(rType(5'd1, 5'd2, 5'd17, 6'b100101));
        misc.push_back(rType(5'd1, 5'd2, 5'd18, 6'b100111));
        misc.push_back(rType(5'd1, 5'd2, 5'd19, 6'b101010));
        misc.push_back(rType(5'd0, 5'd2, 5'd20, 6'b000000));
        misc.push_back(rType(5'd0, 5'd2, 5'd21, 6'b000010));
        misc.push_back(rType(5'd0, 5'd0, 5'd22, 6'b010000));
        foreach (misc[i]) begin
            applyStimulus($sformatf("t4_misc%0d", i), misc[i], 1'b1, 1'b0, 1'b0);
        end
        applyStimulus("t4_nop", 32'h0, 1'b0, 1'b0, 1'b0);

        // Illegal encodings, flush, flush with stall, and bubbles ignoring hazards
        applyStimulus("t5_badop",  {6'b111111, 26'h0}, 1'b1, 1'b0, 1'b0);
        applyStimulus("t5_badfn",  rType(5'd1, 5'd2, 5'd3, 6'b111111), 1'b1, 1'b0, 1'b0);
        applyStimulus("t5_flush",  rType(5'd1, 5'd2, 5'd4, 6'b100000), 1'b1, 1'b1, 1'b0);
        applyStimulus("t5_lw",     iType(OP_LW, 5'd1, 5'd9, 16'h0), 1'b1, 1'b0, 1'b0);
        applyStimulus("t5_fl_st",  rType(5'd9, 5'd9, 5'd10, 6'b100000), 1'b1, 1'b1, 1'b1);
        applyStimulus("t5_add",    rType(5'd9, 5'd9, 5'd10, 6'b100000), 1'b1, 1'b0, 1'b0);
        applyStimulus("t5_lw2",    iType(OP_LW, 5'd1, 5'd9, 16'h0), 1'b1, 1'b0, 1'b0);
        applyStimulus("t5_inval",  rType(5'd9, 5'd9, 5'd10, 6'b100000), 1'b0, 1'b0, 1'b0);
        applyStimulus("t5_nop",    32'h0, 1'b0, 1'b0, 1'b0);

        // Reset while the multiplier is busy, then a fresh mult issues at once
        applyStimulus("t6_mult", rType(5'd1, 5'd2, 5'd0, 6'b011000), 1'b1, 1'b0, 1'b0);
        applyStimulus("t6_nop",  32'h0, 1'b0, 1'b0, 1'b0);
        doReset("t6_reset");
        applyStimulus("t6_mult2", rType(5'd3, 5'd4, 5'd0, 6'b011000), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            applyStimulus($sformatf("t6_mfhi_s%0d", i), rType(5'd0, 5'd0, 5'd23, 6'b010000),
                          1'b1, 1'b0, 1'b1);
        end
        applyStimulus("t6_mfhi",  rType(5'd0, 5'd0, 5'd23, 6'b010000), 1'b1, 1'b0, 1'b0);
        applyStimulus("t6_nop1",  32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus("t6_nop2",  32'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
